// File: rtl/usb_ep_ctrl_if.sv
// usb_ep_ctrl_if: transaction port between the USB core and the endpoint
// controller. The core side (master) reports transaction status and byte
// strobes. The controller side (slave) returns the handshake, the data toggle
// and the IN data.
interface usb_ep_ctrl_if;
    logic       transaction_active;
    logic [3:0] endpoint;
    logic       direction_in;
    logic       setup;
    logic [7:0] data_out;
    logic       data_strobe;
    logic       success;
    logic [1:0] handshake;
    logic       data_toggle;
    logic [7:0] data_in;
    logic       data_in_valid;

    modport master (
        output transaction_active, endpoint, direction_in, setup,
        output data_out, data_strobe, success,
        input  handshake, data_toggle, data_in, data_in_valid
    );

    modport slave (
        input  transaction_active, endpoint, direction_in, setup,
        input  data_out, data_strobe, success,
        output handshake, data_toggle, data_in, data_in_valid
    );
endinterface

// File: rtl/usb_ep_ctrl.sv
// usb_ep_ctrl: shares one USB core transaction port among NUM_EP endpoints.
// Each endpoint keeps the following state: IN-armed, OUT-ready, stall, and one
// DATA0/1 toggle per direction. Core byte strobes become app buffer
// reads and writes at {ep, offset}. A done pulse reports each committed
// transaction.
// Optional feature macro: USB_EP_NAK_CNT_EN enables the saturating NAK counter
// (when the macro is undefined, nak_count is tied to zero).
// Endpoint tables are sized for the full 4-bit endpoint space. Entries at or
// above NUM_EP are never written, so they stay at zero.
module usb_ep_ctrl #(
    parameter int NUM_EP  = 4,
    parameter int MAX_PKT = 64
) (
    input  logic              clk_48,
    input  logic              rst_n,
    input  logic              usb_rst,
    usb_ep_ctrl_if.slave      core,
    input  logic              in_arm,
    input  logic [3:0]        arm_ep,
    input  logic [6:0]        in_len,
    input  logic              out_arm,
    input  logic              stall_set,
    input  logic              stall_clr,
    output logic [10:0]       buf_addr,
    input  logic [7:0]        buf_rdata,
    output logic              buf_wr,
    output logic [7:0]        buf_wdata,
    output logic              done,
    output logic [3:0]        done_ep,
    output logic              done_in,
    output logic              done_setup,
    output logic [6:0]        done_len,
    output logic              done_ovf,
    output logic [15:0]       nak_count
);

    localparam logic [4:0] NUM_EP_L  = 5'(NUM_EP);
    localparam logic [6:0] MAX_PKT_L = 7'(MAX_PKT);
    localparam logic [1:0] HS_ACK    = 2'b00;
    localparam logic [1:0] HS_NAK    = 2'b10;
    localparam logic [1:0] HS_STALL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_COMMIT = 2'b10,
        ST_WAIT   = 2'b11
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [15:0] armed_r;
    logic [15:0] ready_r;
    logic [15:0] stall_r;
    logic [15:0] tog_in_r;
    logic [15:0] tog_out_r;
    logic [6:0]  len_r [16];

    logic [3:0]  ep_r;
    logic        dir_r;
    logic        setup_r;
    logic [6:0]  offset_r;
    logic        ovf_r;

    logic        ep_ok_s;
    logic        ep_r_ok_s;
    logic        arm_ok_s;
    logic [1:0]  handshake_s;
    logic        toggle_s;
    logic [6:0]  offset_nxt_s;
    logic        ovf_nxt_s;
    logic        wr_s;

    assign ep_ok_s   = ({1'b0, core.endpoint} < NUM_EP_L);
    assign ep_r_ok_s = ({1'b0, ep_r} < NUM_EP_L);
    assign arm_ok_s  = ({1'b0, arm_ep} < NUM_EP_L);

    // Handshake for the transaction currently presented by the core
    always_comb begin
        handshake_s = HS_NAK;
        if (!core.transaction_active) begin
            handshake_s = HS_NAK;
        end else if (!ep_ok_s) begin
            handshake_s = HS_STALL;
        end else if (core.setup) begin
            handshake_s = HS_ACK;
        end else if (stall_r[core.endpoint]) begin
            handshake_s = HS_STALL;
        end else if (core.direction_in) begin
            handshake_s = armed_r[core.endpoint] ? HS_ACK : HS_NAK;
        end else begin
            handshake_s = ready_r[core.endpoint] ? HS_ACK : HS_NAK;
        end
    end

    // Data toggle: SETUP always uses DATA0, otherwise the per-direction bit
    always_comb begin
        toggle_s = 1'b0;
        if (core.setup) begin
            toggle_s = 1'b0;
        end else if (core.direction_in) begin
            toggle_s = tog_in_r[core.endpoint];
        end else begin
            toggle_s = tog_out_r[core.endpoint];
        end
    end

    assign core.handshake     = handshake_s;
    assign core.data_toggle   = toggle_s;
    assign core.data_in       = buf_rdata;
    assign core.data_in_valid = (state_r == ST_ACTIVE) && dir_r && (offset_r < len_r[ep_r]);

    // Byte accounting for one strobe. The offset saturates at MAX_PKT, and
    // OUT bytes beyond MAX_PKT set the overflow flag instead of being written.
    always_comb begin
        offset_nxt_s = offset_r;
        ovf_nxt_s    = ovf_r;
        wr_s         = 1'b0;
        if ((state_r == ST_ACTIVE) && core.data_strobe) begin
            if (offset_r < MAX_PKT_L) begin
                offset_nxt_s = offset_r + 7'd1;
                wr_s         = !dir_r;
            end else begin
                ovf_nxt_s    = ovf_r | !dir_r;
            end
        end else begin
            offset_nxt_s = offset_r;
        end
    end

    // Next-state logic of the transaction FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (core.transaction_active) begin
                    state_nxt_s = ST_ACTIVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (core.success) begin
                    state_nxt_s = ST_COMMIT;
                end else if (!core.transaction_active) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_COMMIT: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (!core.transaction_active) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register; a bus reset returns to IDLE at once
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else if (usb_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Transaction datapath: latch context, track offset, drive buffer port and done
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            ep_r       <= 4'd0;
            dir_r      <= 1'b0;
            setup_r    <= 1'b0;
            offset_r   <= 7'd0;
            ovf_r      <= 1'b0;
            buf_addr   <= 11'd0;
            buf_wr     <= 1'b0;
            buf_wdata  <= 8'd0;
            done       <= 1'b0;
            done_ep    <= 4'd0;
            done_in    <= 1'b0;
            done_setup <= 1'b0;
            done_len   <= 7'd0;
            done_ovf   <= 1'b0;
        end else if (usb_rst) begin
            ep_r       <= 4'd0;
            dir_r      <= 1'b0;
            setup_r    <= 1'b0;
            offset_r   <= 7'd0;
            ovf_r      <= 1'b0;
            buf_addr   <= 11'd0;
            buf_wr     <= 1'b0;
            buf_wdata  <= 8'd0;
            done       <= 1'b0;
            done_ep    <= 4'd0;
            done_in    <= 1'b0;
            done_setup <= 1'b0;
            done_len   <= 7'd0;
            done_ovf   <= 1'b0;
        end else begin
            buf_wr <= 1'b0;
            done   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (core.transaction_active) begin
                        ep_r     <= core.endpoint;
                        dir_r    <= core.direction_in;
                        setup_r  <= core.setup;
                        offset_r <= 7'd0;
                        ovf_r    <= 1'b0;
                        buf_addr <= {core.endpoint, 7'd0};
                    end
                end
                ST_ACTIVE: begin
                    offset_r <= offset_nxt_s;
                    ovf_r    <= ovf_nxt_s;
                    if (wr_s) begin
                        // The OUT write lands on the offset that was just consumed
                        buf_wr    <= 1'b1;
                        buf_wdata <= core.data_out;
                        buf_addr  <= {ep_r, offset_r};
                    end else if (dir_r) begin
                        // The IN read address runs ahead to the next byte
                        buf_addr  <= {ep_r, offset_nxt_s};
                    end
                    if (core.success) begin
                        done       <= 1'b1;
                        done_ep    <= ep_r;
                        done_in    <= dir_r;
                        done_setup <= setup_r;
                        done_len   <= offset_nxt_s;
                        done_ovf   <= ovf_nxt_s;
                    end
                end
                default: begin
                    offset_r <= offset_r;
                end
            endcase
        end
    end

    // Per-endpoint status: app requests first, then COMMIT clears override them
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            armed_r   <= 16'd0;
            ready_r   <= 16'd0;
            stall_r   <= 16'd0;
            tog_in_r  <= 16'd0;
            tog_out_r <= 16'd0;
            for (int i = 0; i < 16; i++) begin
                len_r[i] <= 7'd0;
            end
        end else if (usb_rst) begin
            armed_r   <= 16'd0;
            ready_r   <= 16'd0;
            stall_r   <= 16'd0;
            tog_in_r  <= 16'd0;
            tog_out_r <= 16'd0;
            for (int i = 0; i < 16; i++) begin
                len_r[i] <= 7'd0;
            end
        end else begin
            if (in_arm && arm_ok_s && !armed_r[arm_ep]) begin
                armed_r[arm_ep] <= 1'b1;
                len_r[arm_ep]   <= in_len;
            end
            if (out_arm && arm_ok_s && !ready_r[arm_ep]) begin
                ready_r[arm_ep] <= 1'b1;
            end
            if (stall_set && arm_ok_s) begin
                stall_r[arm_ep] <= 1'b1;
            end else if (stall_clr && arm_ok_s) begin
                stall_r[arm_ep] <= 1'b0;
            end
            if ((state_r == ST_COMMIT) && ep_r_ok_s) begin
                if (setup_r) begin
                    tog_out_r[ep_r] <= 1'b1;
                    tog_in_r[ep_r]  <= 1'b1;
                    stall_r[ep_r]   <= 1'b0;
                    ready_r[ep_r]   <= 1'b0;
                    armed_r[ep_r]   <= 1'b0;
                end else if (dir_r) begin
                    tog_in_r[ep_r]  <= ~tog_in_r[ep_r];
                    armed_r[ep_r]   <= 1'b0;
                end else begin
                    tog_out_r[ep_r] <= ~tog_out_r[ep_r];
                    ready_r[ep_r]   <= 1'b0;
                end
            end
        end
    end

`ifdef USB_EP_NAK_CNT_EN
    logic [15:0] nak_cnt_r;

    // Count transactions that enter ACTIVE with a NAK handshake, saturating
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            nak_cnt_r <= 16'd0;
        end else if (usb_rst) begin
            nak_cnt_r <= 16'd0;
        end else if ((state_r == ST_IDLE) && core.transaction_active &&
                     (handshake_s == HS_NAK) && (nak_cnt_r != 16'hFFFF)) begin
            nak_cnt_r <= nak_cnt_r + 16'd1;
        end else begin
            nak_cnt_r <= nak_cnt_r;
        end
    end

    assign nak_count = nak_cnt_r;
`else
    assign nak_count = 16'd0;
`endif

endmodule
